// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit and the CPU control unit:
// FSM state encodings, default bus widths and a small sizing helper.
package mem_access_unit_pkg;

  // Default widths; AW must match memory_module's address width.
  localparam int AW_DEFAULT = 4;
  localparam int DW_DEFAULT = 8;

  // FSM state encodings, kept as plain 2-bit constants so older code
  // that compares raw state values keeps working.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Larger of two integers, used to size the strobe down-counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Memory access unit: bus master between the CPU control unit and
// memory_module. Takes one load/store at a time, holds the read or write
// strobe for a fixed number of cycles, captures load data and presents a
// response that is held until the CPU takes it.
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid and ready are both 1. The requester must hold valid and
// its payload stable until that edge; a valid seen while ready=0 is ignored.
// The response payload (resp_write, resp_rdata) is stable while resp_valid=1.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int AW        = AW_DEFAULT,
  parameter int DW        = DW_DEFAULT,
  parameter int RD_LAT    = 2,
  parameter int WR_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp_write,
  output logic [DW-1:0] resp_rdata,
  output logic [AW-1:0] mem_address,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out
);

  // Counter holds "strobe cycles remaining after this one", so it is loaded
  // with N-1 and the strobe drops on the edge where it reads zero.
  localparam int CW = $clog2(max_int(RD_LAT, WR_CYCLES) + 1);

  logic [1:0]    state;
  logic [CW-1:0] counter;

  // Single registered FSM: every output is a flop, no combinational paths
  // from inputs to outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      counter     <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_write  <= 1'b0;
      resp_rdata  <= '0;
      mem_address <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_data_in <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            mem_address <= req_addr;
            resp_write  <= req_write;
            req_ready   <= 1'b0;
            if (req_write) begin
              mem_data_in <= req_wdata;
              mem_write   <= 1'b1;
              counter     <= CW'(WR_CYCLES - 1);
              state       <= ST_WRITE;
            end else begin
              mem_read <= 1'b1;
              counter  <= CW'(RD_LAT - 1);
              state    <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (counter == '0) begin
            mem_write  <= 1'b0;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end else begin
            counter <= counter - CW'(1);
          end
        end
        ST_READ: begin
          if (counter == '0) begin
            resp_rdata <= mem_data_out;
            mem_read   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end else begin
            counter <= counter - CW'(1);
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit with a behavioural memory_module stand-in
// (registered read, synchronous write).
module tb_mem_access_unit;

  localparam int AW = 4;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready, resp_write;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] mem_address;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_data_in, mem_data_out;

  mem_access_unit #(.AW(AW), .DW(DW), .RD_LAT(2), .WR_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_write(resp_write), .resp_rdata(resp_rdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // memory_module model: registered read, synchronous write
  logic [DW-1:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem_data_out = '0;
  end
  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_data_in;
    if (mem_read)  mem_data_out <= mem[mem_address];
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW:0]   exp_q[$];        // {resp_write, resp_rdata}
  logic [DW-1:0] ref_mem [16];    // golden memory contents
  logic [DW-1:0] last_load = '0;  // resp_rdata the DUT should hold

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic          hold_prev = 1'b0;
  logic [DW-1:0] hold_rdata;
  logic          hold_write;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      check("strobe_exclusive", 32'(mem_read & mem_write), 32'd0);
      if (hold_prev) begin
        check("hold_valid", 32'(resp_valid), 32'd1);
        check("hold_rdata", 32'(resp_rdata), 32'(hold_rdata));
        check("hold_write", 32'(resp_write), 32'(hold_write));
      end
      hold_prev  = resp_valid && !resp_ready;
      hold_rdata = resp_rdata;
      hold_write = resp_write;
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("resp_write", 32'(resp_write), 32'(e[DW]));
          check("resp_rdata", 32'(resp_rdata), 32'(e[DW-1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Wait for req_ready, present the request, return #1 after the accept edge.
  task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int budget = 0;
    @(negedge clk);
    while (!req_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
    if (w) begin
      exp_q.push_back({1'b1, last_load});
      ref_mem[a] = d;
    end else begin
      exp_q.push_back({1'b0, ref_mem[a]});
      last_load = ref_mem[a];
    end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; resp_ready = 1;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    #12;
    check("rst_req_ready",  32'(req_ready),   32'd1);
    check("rst_resp_valid", 32'(resp_valid),  32'd0);
    check("rst_resp_rdata", 32'(resp_rdata),  32'd0);
    check("rst_mem_addr",   32'(mem_address), 32'd0);
    check("rst_strobes",    32'({mem_read, mem_write}), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // 1: store F0 -> addr 1
    do_req(1'b1, 4'h1, 8'hF0);
    check("t1_mem_write", 32'(mem_write),   32'd1);
    check("t1_mem_addr",  32'(mem_address), 32'd1);
    check("t1_mem_din",   32'(mem_data_in), 32'hF0);
    check("t1_no_resp",   32'(resp_valid),  32'd0);
    step();
    check("t1_write_off", 32'(mem_write),  32'd0);
    check("t1_resp",      32'(resp_valid), 32'd1);
    check("t1_resp_wr",   32'(resp_write), 32'd1);
    check("t1_busy",      32'(req_ready),  32'd0);
    step();
    check("t1_ready_back", 32'(req_ready),  32'd1);
    check("t1_resp_done",  32'(resp_valid), 32'd0);

    // 2: load addr 1
    do_req(1'b0, 4'h1, 8'h00);
    check("t2_read_c1", 32'(mem_read),   32'd1);
    check("t2_noresp1", 32'(resp_valid), 32'd0);
    step();
    check("t2_read_c2", 32'(mem_read),   32'd1);
    check("t2_noresp2", 32'(resp_valid), 32'd0);
    step();
    check("t2_read_off", 32'(mem_read),   32'd0);
    check("t2_resp",     32'(resp_valid), 32'd1);
    check("t2_rdata",    32'(resp_rdata), 32'hF0);
    check("t2_resp_wr",  32'(resp_write), 32'd0);
    drain();

    // 3: load with resp_ready low for 5 cycles
    resp_ready = 1'b0;
    do_req(1'b0, 4'h1, 8'h00);
    step(); step();
    for (int i = 0; i < 5; i++) begin
      check("t3_held_valid", 32'(resp_valid), 32'd1);
      check("t3_held_rdata", 32'(resp_rdata), 32'hF0);
      check("t3_not_idle",   32'(req_ready),  32'd0);
      step();
    end
    resp_ready = 1'b1;
    step();
    check("t3_idle",     32'(req_ready),  32'd1);
    check("t3_released", 32'(resp_valid), 32'd0);
    drain();

    // 4: second request during READ is ignored until the first completes
    do_req(1'b0, 4'h1, 8'h00);
    exp_q.push_back({1'b1, last_load});
    ref_mem[5] = 8'h33;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h5; req_wdata = 8'h33;
    budget = 0;
    @(negedge clk);
    while (!req_ready && budget < 50) begin
      check("t4_addr_held", 32'(mem_address), 32'd1);
      @(negedge clk);
      budget++;
    end
    check("t4_accept_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check("t4_new_addr",  32'(mem_address), 32'd5);
    check("t4_new_write", 32'(mem_write),   32'd1);
    drain();

    // 5: asynchronous reset in the first READ cycle
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_req_ready", 32'(req_ready),   32'd1);
    check("t5_read_off",  32'(mem_read),    32'd0);
    check("t5_addr_zero", 32'(mem_address), 32'd0);
    check("t5_resp_zero", 32'(resp_valid),  32'd0);
    check("t5_din_zero",  32'(mem_data_in), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    last_load = '0;
    repeat (4) begin
      step();
      check("t5_no_resp", 32'(resp_valid), 32'd0);
    end
    do_req(1'b1, 4'h2, 8'h5A);
    do_req(1'b0, 4'h2, 8'h00);
    drain();

    // 6: fill all addresses, read them back
    for (int i = 0; i < 16; i++) do_req(1'b1, 4'(i), 8'(i * 17) ^ 8'h3C);
    for (int i = 0; i < 16; i++) do_req(1'b0, 4'(i), 8'h00);
    drain();

    repeat (5) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Bus master that drives memory_module's port (address, read, write, data_in, data_out) on behalf of the CPU datapath.
- Accepts one load/store request at a time over a valid/ready handshake.
- Sequences the memory strobes for a fixed number of cycles, captures read data, and returns a response held until the CPU acknowledges it.
- Sits between the CPU control unit and memory_module.

Parameters:
- AW, 4, address width; must match memory_module.
- DW, 8, data width.
- RD_LAT, 2, cycles mem_read is held before mem_data_out is sampled; minimum 1.
- WR_CYCLES, 1, cycles mem_write is held; minimum 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  AW  request address.
- req_wdata  in  DW  store data.
- resp_valid  out  1  response available.
- resp_ready  in  1  CPU accepts the response.
- resp_write  out  1  response belongs to a store.
- resp_rdata  out  DW  load data.
- mem_address  out  AW  to memory_module address.
- mem_read  out  1  to memory_module read.
- mem_write  out  1  to memory_module write.
- mem_data_in  out  DW  to memory_module data_in.
- mem_data_out  in  DW  from memory_module data_out.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low. All outputs are registered.
- Reset values: req_ready=1, resp_valid=0, resp_write=0, resp_rdata=0, mem_address=0, mem_read=0, mem_write=0, mem_data_in=0; state=IDLE, counter=0.
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - req_ready=1.
  - On a clock edge with req_valid=1: latch req_addr into mem_address and req_wdata into mem_data_in (store only), set resp_write=req_write, clear req_ready, load counter.
  - Next state is WRITE if req_write=1, otherwise READ.
- WRITE:
  - mem_write=1 for exactly WR_CYCLES cycles; mem_address and mem_data_in held stable.
  - On the last cycle's edge: mem_write=0, resp_valid=1, go to RESP.
  - resp_rdata is unchanged by stores.
- READ:
  - mem_read=1 for exactly RD_LAT cycles; mem_address held stable.
  - On the edge ending the RD_LAT-th cycle: resp_rdata<=mem_data_out, mem_read=0, resp_valid=1, go to RESP.
  - RD_LAT=2 covers memory_module's registered read.
- RESP:
  - resp_valid stays 1 and resp_rdata/resp_write stay stable until an edge with resp_ready=1.
  - Then resp_valid=0, req_ready=1, go to IDLE.
  - If resp_ready was already high on entry, the unit spends exactly one cycle in RESP.
- Latency, request edge to resp_valid high: load = RD_LAT cycles; store = WR_CYCLES cycles.
- Back-to-back throughput: one transaction per (latency + 2) cycles minimum.
- Boundaries:
  - req_valid while req_ready=0 is ignored; the CPU must hold it.
  - mem_read and mem_write are never 1 simultaneously.
  - Strobes are never high outside WRITE/READ.
  - Address AW'h{all ones} is a normal address; no wrap logic.
  - Counter is sized $clog2(max(RD_LAT,WR_CYCLES)+1) and never wraps.
- Reset mid-operation: immediate return to reset values; the in-flight transaction is dropped; no response issued; memory contents are not protected if a write was in progress.
- mem_address and mem_data_in keep their last value in IDLE and RESP; they return to 0 only on reset.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, WRITE=2'd1, READ=2'd2, RESP=2'd3) and the default AW/DW constants, reused by the CPU control unit.
- No sub-module; the FSM plus one down-counter is a single module.
- Benches instantiate memory_module as the memory model.

Test Plan:
1. Store 8'hF0 to address 4'h1, resp_ready=1 -> mem_write high exactly 1 cycle with mem_address=1 and mem_data_in=F0; resp_valid with resp_write=1 one cycle after the request edge; req_ready back high the following cycle.
2. Load from address 4'h1 after scenario 1 -> mem_read high 2 cycles; resp_valid 2 cycles after the request edge with resp_rdata=8'hF0, resp_write=0.
3. Load with resp_ready held low 5 cycles -> resp_valid and resp_rdata stay stable all 5 cycles; IDLE entered only on the edge where resp_ready=1.
4. Second req_valid asserted during READ with different address and data -> ignored (req_ready=0, mem_address unchanged); accepted only after the first response completes.
5. Assert rst_n=0 asynchronously in the middle of the first READ cycle -> all outputs return to reset values immediately; no resp_valid after release; next request behaves normally.
6. Write 16 distinct values to addresses 0..F, then read all back (including address F) -> every resp_rdata matches; mem_read and mem_write are never high together.
